// File: rtl/aging_sched.sv
// aging_sched: walks a masked set of ring-oscillator sensors, counts edges per sensor over a window, reports results
// Ports: clk/rst_b (sync, active-low); start/stop/cont_mode control; sensor_mask, win_len sampled at start;
//        ro_div async oscillator inputs; ro_en one-hot enable; res_valid/res_ready/res_id/res_count result port;
//        busy (not IDLE); done (pulse at pass end or abort).
// Optional AGING_SCHED_OVF_FLAG_EN: adds res_ovf (window saturated) and sticky ovf_seen (cleared on start).
module aging_sched #(
   parameter int NUM_SENSORS = 4,
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SETTLE_CYC  = 8
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   cont_mode,
   input  logic [NUM_SENSORS-1:0] sensor_mask,
   input  logic [WIN_W-1:0]       win_len,
   input  logic [NUM_SENSORS-1:0] ro_div,
   output logic [NUM_SENSORS-1:0] ro_en,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [3:0]             res_id,
   output logic [CNT_W-1:0]       res_count,
   output logic                   busy,
   output logic                   done
`ifdef AGING_SCHED_OVF_FLAG_EN
   ,
   output logic                   res_ovf,
   output logic                   ovf_seen
`endif
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = WIN_W > SW ? WIN_W : SW;
   typedef enum logic [2:0] {IDLE, SELECT, SETTLE, MEASURE, REPORT} state_t;
   state_t state, state_nx;
   logic [NUM_SENSORS-1:0] mask_q, s1, s2, s3;
   logic [15:0] edge_w;
   logic [WIN_W-1:0] win_q;
   logic [TW-1:0] tmr;
   logic [3:0] cur_id, id_nx;
   logic [4:0] low_in, low_q, nxt_hi;
   logic [CNT_W-1:0] cnt;
   logic abort, stop_any, done_nx, settle_end, win_end;

   // lowest set bit of m at index >= lo, as {found, index}
   function automatic logic [4:0] first_set(input logic [NUM_SENSORS-1:0] m, input logic [4:0] lo);
      first_set = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--)
         if (m[i] && 5'(i) >= lo) first_set = {1'b1, 4'(i)};
   endfunction

   assign edge_w     = 16'(s2 & ~s3);
   assign low_in     = first_set(sensor_mask, 5'd0);
   assign low_q      = first_set(mask_q, 5'd0);
   assign nxt_hi     = first_set(mask_q, {1'b0, cur_id} + 5'd1);
   assign stop_any   = abort | stop;
   assign settle_end = tmr == TW'(SETTLE_CYC - 1);
   assign win_end    = tmr == TW'(win_q - WIN_W'(1));
   assign ro_en      = (state == SELECT || state == SETTLE || state == MEASURE) ? NUM_SENSORS'(1) << cur_id : '0;
   assign busy       = state != IDLE;
   assign res_valid  = state == REPORT;
   assign res_id     = cur_id;
   assign res_count  = cnt;

   always_comb begin
      state_nx = state;
      id_nx    = cur_id;
      case (state)
         IDLE:    if (start && low_in[4]) begin
                     state_nx = SELECT;
                     id_nx    = low_in[3:0];
                  end
         SELECT:  state_nx = stop_any ? IDLE : SETTLE;
         SETTLE:  if (settle_end) state_nx = stop_any ? IDLE : MEASURE;
         MEASURE: if (win_end) state_nx = stop_any ? IDLE : REPORT;
         REPORT:  if (res_ready) begin
                     if (stop_any) state_nx = IDLE;
                     else if (nxt_hi[4]) begin
                        state_nx = SELECT;
                        id_nx    = nxt_hi[3:0];
                     end else if (cont_mode) begin
                        state_nx = SELECT;
                        id_nx    = low_q[3:0];
                     end else state_nx = IDLE;
                  end
         default: state_nx = IDLE;
      endcase
      done_nx = (state == IDLE) ? (start && !low_in[4]) : (state_nx == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state  <= IDLE;
         cur_id <= '0;
         done   <= 1'b0;
         abort  <= 1'b0;
         mask_q <= '0;
         win_q  <= '0;
         tmr    <= '0;
         cnt    <= '0;
         {s3, s2, s1} <= '0;
      end else begin
         state  <= state_nx;
         cur_id <= id_nx;
         done   <= done_nx;
         abort  <= (state_nx == IDLE) ? 1'b0 : (abort | (stop & busy));
         {s3, s2, s1} <= {s2, s1, ro_div};
         if (state == IDLE && start) begin
            mask_q <= sensor_mask;
            win_q  <= (win_len == '0) ? WIN_W'(1) : win_len;
         end
         tmr <= (state_nx != state) ? '0 : tmr + 1'b1;
         if (state == SELECT) cnt <= '0;
         else if (state == MEASURE && edge_w[cur_id] && !(&cnt)) cnt <= cnt + 1'b1;
      end
   end

`ifdef AGING_SCHED_OVF_FLAG_EN
   logic sat;
   // an edge arriving while the counter is already full is a lost count
   assign sat = state == MEASURE && edge_w[cur_id] && (&cnt);

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         res_ovf  <= 1'b0;
         ovf_seen <= 1'b0;
      end else begin
         if (state == SELECT) res_ovf <= 1'b0;
         else if (sat) res_ovf <= 1'b1;
         if (state == IDLE && start) ovf_seen <= 1'b0;
         else if (sat) ovf_seen <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_aging_sched.sv
// tb_aging_sched: randomized and directed bench for aging_sched against a window/edge-count reference model
module tb_aging_sched;
   localparam int NS = 4, CW = 8, WW = 12, S = 5, MAXC = 20000, CMAX = (1 << CW) - 1;
   logic clk = 0, rst_b = 0, start = 0, stop = 0, cont_mode = 0, res_ready = 1;
   logic [NS-1:0] sensor_mask = '0, ro_div = '0, ro_prev = '0, ro_en;
   logic [WW-1:0] win_len = '0;
   logic res_valid, busy, done;
   logic [3:0] res_id;
   logic [CW-1:0] res_count;
`ifdef AGING_SCHED_OVF_FLAG_EN
   logic res_ovf, ovf_seen;
`endif
   int checks = 0, errors = 0, cyc = 0, L = 0;
   int per[NS], ph[NS];
   bit rose[NS][MAXC];

   always #5 clk = ~clk;

   aging_sched #(.NUM_SENSORS(NS), .CNT_W(CW), .WIN_W(WW), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .stop(stop), .cont_mode(cont_mode),
      .sensor_mask(sensor_mask), .win_len(win_len), .ro_div(ro_div), .ro_en(ro_en),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count),
      .busy(busy), .done(done)
`ifdef AGING_SCHED_OVF_FLAG_EN
      , .res_ovf(res_ovf), .ovf_seen(ovf_seen)
`endif
   );

   // cyc = index of the last rising edge; rose[s][k] = ro_div[s] rose as sampled at edge k
   always @(posedge clk) begin
      cyc <= cyc + 1;
      ro_prev <= ro_div;
      for (int s = 0; s < NS; s++)
         if (cyc + 1 < MAXC) rose[s][cyc + 1] <= ro_div[s] & ~ro_prev[s];
   end

   always @(negedge clk)
      for (int s = 0; s < NS; s++)
         ro_div[s] <= per[s] > 0 && ((cyc + ph[s]) % per[s]) < per[s] / 2;

   always @(negedge clk)
      if (rst_b) begin
         checks++;
         assert ($onehot0(ro_en)) else begin errors++; $error("FAIL onehot ro_en obs=%b", ro_en); end
      end

   initial begin
      #600000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin errors++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp); end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int rises(input int s, input int a, input int b);
      int n = 0;
      for (int k = (a < 0 ? 0 : a); k < b && k < MAXC; k++) n += int'(rose[s][k]);
      return n;
   endfunction

   task automatic launch(input logic [NS-1:0] m, input int w);
      sensor_mask = m;
      win_len = WW'(w);
      start = 1;
      step;
      start = 0;
      L = cyc;
   endtask

   // L = edge at which the sensor's SELECT was entered; counted edges may shift by the 3-cycle synchronizer
   task automatic get_result(input int id, input int weff, input int hold);
      int t0, lo, hi, hi_raw, ms, c, h;
      t0 = cyc;
      chk("ro_en_sel", ro_en, 1 << id);
      chk("busy_run", busy, 1);
      while (!res_valid && cyc - t0 < 3000) step;
      chk("rv_time", cyc, L + 1 + S + weff);
      chk("res_id", res_id, id);
      ms = L + 1 + S;
      lo = rises(id, ms, ms + weff - 3);
      hi_raw = rises(id, ms - 3, ms + weff);
      lo = lo > CMAX ? CMAX : lo;
      hi = hi_raw > CMAX ? CMAX : hi_raw;
      c = int'(res_count);
      checks++;
      assert (c >= lo && c <= hi) else begin errors++; $error("FAIL res_count obs=%0d exp=%0d..%0d", c, lo, hi); end
      chk("ro_en_rep", ro_en, 0);
`ifdef AGING_SCHED_OVF_FLAG_EN
      if (hi_raw <= CMAX) chk("res_ovf_clr", res_ovf, 0);
`endif
      h = hold < 0 ? int'($urandom_range(3)) : hold;
      if (h > 0) begin
         res_ready = 0;
         repeat (h) begin
            step;
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, id);
            chk("hold_cnt", res_count, c);
            chk("hold_ro_en", ro_en, 0);
         end
         res_ready = 1;
      end
      step;
      L = cyc;
   endtask

   task automatic expect_done;
      chk("done", done, 1);
      chk("busy_fall", busy, 0);
      chk("ro_en_idle", ro_en, 0);
      step;
      chk("done_pulse", done, 0);
   endtask

   initial begin
      int bad;
      logic [NS-1:0] m;
      int w;
      repeat (3) step;
      chk("rst_ro_en", ro_en, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_id", res_id, 0);
      chk("rst_cnt", res_count, 0);
      rst_b = 1;
      step;

      per[1] = 4;
      per[3] = 10;
      repeat (20) step;
      launch(4'b1010, 100);
      get_result(1, 100, 0);
      get_result(3, 100, 0);
      expect_done();

      launch(4'b0000, 5);
      chk("m0_done", done, 1);
      chk("m0_busy", busy, 0);
      step;
      chk("m0_done_end", done, 0);
      chk("m0_busy_end", busy, 0);

      per[2] = 6;
      launch(4'b0100, 0);
      get_result(2, 1, 0);
      expect_done();

      launch(4'b0110, 16);
      get_result(1, 16, 20);
      get_result(2, 16, 0);
      expect_done();

      per[0] = 5;
      launch(4'b0011, 30);
      step;
      step;
      sensor_mask = 4'b1000;
      win_len = 3;
      start = 1;
      step;
      start = 0;
      get_result(0, 30, 0);
      get_result(1, 30, 0);
      expect_done();

      cont_mode = 1;
      launch(4'b0001, 12);
      repeat (3) get_result(0, 12, 0);
      while (cyc < L + 1 + S + 3) step;
      stop = 1;
      step;
      stop = 0;
      while (cyc < L + S + 12) step;
      chk("abort_wait_busy", busy, 1);
      step;
      chk("abort_done", done, 1);
      chk("abort_busy", busy, 0);
      chk("abort_valid", res_valid, 0);
      chk("abort_ro_en", ro_en, 0);
      cont_mode = 0;
      bad = 0;
      repeat (30) begin step; bad |= int'(res_valid | busy); end
      chk("abort_quiet", bad, 0);

      launch(4'b0010, 20);
      step;
      step;
      rst_b = 0;
      step;
      chk("mid_rst_ro_en", ro_en, 0);
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_id", res_id, 0);
      chk("mid_rst_cnt", res_count, 0);
      rst_b = 1;
      bad = 0;
      repeat (40) begin step; bad |= int'(res_valid | done | busy); end
      chk("post_rst_quiet", bad, 0);

      per[0] = 4;
      launch(4'b0001, 1100);
      get_result(0, 1100, 0);
      chk("sat_cnt", res_count, CMAX);
`ifdef AGING_SCHED_OVF_FLAG_EN
      chk("sat_ovf", res_ovf, 1);
      chk("sat_seen", ovf_seen, 1);
`endif
      expect_done();
`ifdef AGING_SCHED_OVF_FLAG_EN
      launch(4'b0001, 10);
      chk("seen_clr", ovf_seen, 0);
      get_result(0, 10, 0);
      expect_done();
`endif

      repeat (6) begin
         for (int s = 0; s < NS; s++) begin
            per[s] = int'($urandom_range(4, 13));
            ph[s] = int'($urandom_range(0, 12));
         end
         repeat (15) step;
         m = NS'($urandom_range(1, 15));
         w = int'($urandom_range(1, 60));
         launch(m, w);
         for (int id = 0; id < NS; id++)
            if (m[id]) get_result(id, w, -1);
         expect_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
